hamming_serial_enc: RTL and testbench
=====================================

Name: hamming_serial_enc

Overview:
Parametrised serial-in Hamming encoder, the successor to the fixed 4-bit serial encoder.
- Accepts DATA_W data bits one per cycle, LSB first, under a valid qualifier.
- Accumulates parity on the fly and presents a systematic code word with an output-side ready handshake (backpressure).
- Optional extended mode (SECDED) appends an overall parity bit.
- Sits between a serial bit source and the word-level channel/storage path.

Parameters:
DATA_W, 4, number of data bits per word; legal range 1..57.
EXTENDED, 0, 1 appends overall parity bit at MSB of dout (SECDED).
PAR_W, derived localparam, smallest r with 2^r >= DATA_W+r+1 (4->3, 11->4, 26->5).
CODE_W, derived localparam, DATA_W+PAR_W+EXTENDED.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin a new word; sampled only in IDLE.
din  in  1  serial data bit.
din_valid  in  1  din qualifier; only used in SHIFT.
out_ready  in  1  consumer accepts dout while done=1.
ready  out  1  high in IDLE (encoder can take start).
done  out  1  high in DONE; dout valid.
dout  out  CODE_W  {ovr (if EXTENDED), data[DATA_W-1:0], par[PAR_W-1:0]}.

Behaviour:
- Reset (async assert, sync release): state=IDLE, bit_cnt=0, data/par regs=0, dout=0. Reset values: ready=1, done=0, dout=0.
- ready and done are decoded from the state register only (Moore). dout is a register.
- Parity definition:
  - Data bit k (k=0 first received) occupies the k-th non-power-of-two position of the standard Hamming layout (3,5,6,7,9,...).
  - par[i] = XOR of all data bits whose position has bit i set.
  - DATA_W=4 gives par0=d0^d1^d3, par1=d0^d2^d3, par2=d1^d2^d3.
  - ovr = XOR of all data and par bits.
- States:
  - IDLE: start=1 -> SHIFT. Clear bit_cnt and data/par accumulators. din is ignored in IDLE.
  - SHIFT: on each cycle with din_valid=1: data[bit_cnt]<=din; par<=par ^ (din ? MASK[bit_cnt] : 0); bit_cnt++. When bit_cnt==DATA_W-1 with din_valid=1 -> DONE, and dout loads the complete word (including the final bit) on that same edge. din_valid=0 holds all state.
  - DONE: done=1, dout stable. out_ready=1 -> IDLE. out_ready=0 -> stay in DONE.
- Latency: start sampled at edge 0; with continuous din_valid the bits are taken at edges 1..DATA_W and done=1 from edge DATA_W. Each din_valid gap adds one cycle.
- Simultaneous/boundary cases:
  - start in SHIFT or DONE is ignored.
  - out_ready outside DONE is ignored.
  - dout holds its last word through IDLE until the next word completes.
  - bit_cnt width is clog2(DATA_W) (min 1); no wrap, since the terminal count exits SHIFT.
- Reset mid-operation: immediate return to IDLE with dout=0. The partial word is discarded; no done pulse.
- Illegal DATA_W (<1 or >57): elaboration-time error.

Decomposition:
- hamming_pkg holds:
  - function par_width(DATA_W);
  - function data_pos(k), returning the k-th non-power-of-two position;
  - function par_mask(k, PAR_W), returning the low PAR_W bits of data_pos(k);
  - state enum {IDLE, SHIFT, DONE}.
- One sub-module, hamming_par_acc: PAR_W-wide accumulator with clear/enable/din/mask inputs. It is reused by the planned serial decoder's syndrome path.

Test Plan:
1. DATA_W=4, EXTENDED=0: start, then din=1,1,0,1 with din_valid continuously high, out_ready=1 -> done=1 from edge 4, dout=7'b1011001, then IDLE with ready=1.
2. Same word with din_valid low for 3 cycles between bit1 and bit2 -> identical dout=7'b1011001; done delayed by exactly 3 cycles.
3. Backpressure: out_ready=0 for 4 cycles in DONE, with start pulsed during that time -> done held, dout unchanged, ready=0, start ignored; out_ready=1 -> IDLE next edge.
4. Reset mid-word: rst_n low after 2 bits -> ready=1, done=0, dout=0 asynchronously. Next word 0000 -> dout=7'b0000000. Next word 1111 -> dout=7'b1111111.
5. DATA_W=11, EXTENDED=1: all-ones data -> par=4'b1111, ovr=1, dout=16'hFFFF. Data 11'h001 -> par=4'b0011, ovr=1, dout=16'h8013.
6. DATA_W=4: all 16 data words -> each dout matches the golden model, and the receive-side syndrome computed over dout is zero.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the serial Hamming encoder and its companion decoder:
// FSM states and the constant functions that lay data bits into Hamming positions.
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int MAX_DATA_W = 57;
    localparam int MAX_PAR_W  = 6;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int par_width(input int data_w);
        int r;
        r = 1;
        for (int i = 0; i < 8; i++) begin
            if ((1 << r) < data_w + r + 1) r = r + 1;
        end
        return r;
    endfunction

    // k-th non-power-of-two position of the 1-based Hamming layout (3, 5, 6, 7, 9, ...).
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == k && pos == 0) pos = p;
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    function automatic logic [MAX_PAR_W-1:0] par_mask(input int k, input int par_w);
        return MAX_PAR_W'(data_pos(k) & ((1 << par_w) - 1));
    endfunction

endpackage

// File: rtl/hamming_par_acc.sv
// Running parity accumulator: XORs a position mask into the parity register for
// every enabled 1 bit. Shared with the serial decoder's syndrome path.
module hamming_par_acc
    import hamming_pkg::*;
#(
    parameter int PAR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             din,
    input  logic [PAR_W-1:0] mask,
    output logic [PAR_W-1:0] par
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= '0;
        end else if (clear) begin
            par <= '0;
        end else if (enable) begin
            par <= par ^ (mask & {PAR_W{din}});
        end
    end

endmodule

// File: rtl/hamming_serial_enc.sv
// Serial-in systematic Hamming encoder: takes DATA_W bits LSB first and presents
// {ovr (optional), data, par} with a ready/done handshake on the word side.
module hamming_serial_enc
    import hamming_pkg::*;
#(
    parameter int  DATA_W   = 4,
    parameter int  EXTENDED = 0,
    localparam int PAR_W    = par_width(DATA_W),
    localparam int CODE_W   = DATA_W + PAR_W + EXTENDED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              din,
    input  logic              din_valid,
    input  logic              out_ready,
    output logic              ready,
    output logic              done,
    output logic [CODE_W-1:0] dout
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TBL_N = 1 << CNT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
        $error("hamming_serial_enc: DATA_W=%0d outside 1..%0d", DATA_W, MAX_DATA_W);
    end
    if (EXTENDED != 0 && EXTENDED != 1) begin : g_bad_extended
        $error("hamming_serial_enc: EXTENDED must be 0 or 1");
    end

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  data;
    logic [DATA_W-1:0]  data_next;
    logic [PAR_W-1:0]   par;
    logic [PAR_W-1:0]   par_next;
    logic [PAR_W-1:0]   mask;
    logic [PAR_W-1:0]   mask_tbl [TBL_N];
    logic [CODE_W-1:0]  word;
    logic               clear;
    logic               enable;
    logic               last;

    // Unreachable counter values get a zero mask so the table is fully defined.
    for (genvar k = 0; k < TBL_N; k++) begin : g_mask
        if (k < DATA_W) begin : g_used
            assign mask_tbl[k] = PAR_W'(par_mask(k, PAR_W));
        end else begin : g_pad
            assign mask_tbl[k] = '0;
        end
    end

    assign mask   = mask_tbl[bit_cnt];
    assign clear  = (state == IDLE) && start;
    assign enable = (state == SHIFT) && din_valid;
    assign last   = enable && (bit_cnt == LAST_CNT);

    hamming_par_acc #(
        .PAR_W (PAR_W)
    ) u_par_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .enable (enable),
        .din    (din),
        .mask   (mask),
        .par    (par)
    );

    // The final bit is folded in combinationally so dout loads on the same edge.
    always_comb begin
        data_next          = data;
        data_next[bit_cnt] = din;
        par_next           = par ^ (mask & {PAR_W{din}});
    end

    if (EXTENDED != 0) begin : g_ext
        assign word = {^{data_next, par_next}, data_next, par_next};
    end else begin : g_std
        assign word = {data_next, par_next};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            data    <= '0;
            dout    <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
            data    <= '0;
        end else if (enable) begin
            data    <= data_next;
            bit_cnt <= last ? '0 : bit_cnt + CNT_W'(1);
            if (last) dout <= word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hamming_serial_enc.sv
// Bench for hamming_serial_enc: a 4-bit plain and an 11-bit SECDED instance run
// against a word-level Hamming model plus hand-computed code words.
module tb_hamming_serial_enc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_s [2];
    logic        din_s   [2];
    logic        vld_s   [2];
    logic        ordy_s  [2];
    logic        ready_s [2];
    logic        done_s  [2];
    logic [6:0]  dout4;
    logic [15:0] dout11;

    hamming_serial_enc #(.DATA_W(4), .EXTENDED(0)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s[0]),
        .din       (din_s[0]),
        .din_valid (vld_s[0]),
        .out_ready (ordy_s[0]),
        .ready     (ready_s[0]),
        .done      (done_s[0]),
        .dout      (dout4)
    );

    hamming_serial_enc #(.DATA_W(11), .EXTENDED(1)) dut11 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s[1]),
        .din       (din_s[1]),
        .din_valid (vld_s[1]),
        .out_ready (ordy_s[1]),
        .ready     (ready_s[1]),
        .done      (done_s[1]),
        .dout      (dout11)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int dw_of(input int u);
        return (u == 0) ? 4 : 11;
    endfunction

    function automatic int ext_of(input int u);
        return (u == 0) ? 0 : 1;
    endfunction

    // Word-level encoder: place data bits at non-power-of-two positions and
    // XOR the position numbers of all set data bits to obtain the check bits.
    function automatic logic [63:0] model_encode(input logic [63:0] data_in, input int dw, input int ext);
        logic [63:0] data;
        logic [63:0] par;
        logic [63:0] res;
        logic        ovr;
        int          pw;
        int          k;
        int          p;
        data = data_in & ((64'd1 << dw) - 64'd1);
        pw = 1;
        while ((1 << pw) < dw + pw + 1) pw++;
        par = '0;
        k = 0;
        p = 1;
        while (k < dw) begin
            if ((p & (p - 1)) != 0) begin
                if (data[k]) par = par ^ 64'(p);
                k++;
            end
            p++;
        end
        par = par & ((64'd1 << pw) - 64'd1);
        ovr = (^data) ^ (^par);
        res = (data << pw) | par;
        if (ext != 0) res = res | (64'(ovr) << (dw + pw));
        return res;
    endfunction

    // Receiver view: XOR of the positions of every set bit in the code word.
    function automatic int syndrome(input logic [63:0] cw, input int dw, input int pw);
        int s;
        int k;
        int p;
        s = 0;
        for (int i = 0; i < pw; i++) if (cw[i]) s = s ^ (1 << i);
        k = 0;
        p = 1;
        while (k < dw) begin
            if ((p & (p - 1)) != 0) begin
                if (cw[pw + k]) s = s ^ p;
                k++;
            end
            p++;
        end
        return s;
    endfunction

    // Transaction-level model: 0 = waiting for start, 1 = collecting bits, 2 = word held.
    int          m_mode [2];
    int          m_cnt  [2];
    logic [63:0] m_acc  [2];
    logic [63:0] m_dout [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                m_mode[u] <= 0;
                m_cnt[u]  <= 0;
                m_acc[u]  <= '0;
                m_dout[u] <= '0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                case (m_mode[u])
                    0: if (start_s[u]) begin
                        m_mode[u] <= 1;
                        m_cnt[u]  <= 0;
                        m_acc[u]  <= '0;
                    end
                    1: if (vld_s[u]) begin
                        m_acc[u] <= m_acc[u] | (64'(din_s[u]) << m_cnt[u]);
                        m_cnt[u] <= m_cnt[u] + 1;
                        if (m_cnt[u] + 1 == dw_of(u)) begin
                            m_mode[u] <= 2;
                            m_dout[u] <= model_encode(m_acc[u] | (64'(din_s[u]) << m_cnt[u]),
                                                      dw_of(u), ext_of(u));
                        end
                    end
                    default: if (ordy_s[u]) m_mode[u] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("ready4",  64'(ready_s[0]), 64'(m_mode[0] == 0));
        check("done4",   64'(done_s[0]),  64'(m_mode[0] == 2));
        check("dout4",   64'(dout4),      m_dout[0]);
        check("ready11", 64'(ready_s[1]), 64'(m_mode[1] == 0));
        check("done11",  64'(done_s[1]),  64'(m_mode[1] == 2));
        check("dout11",  64'(dout11),     m_dout[1]);
    end

    // Called #1 after a rising edge. Waits (bounded) for ready, pulses start,
    // then feeds n bits LSB first with an optional din_valid gap before bit gap_at.
    // done_at = edges after the start edge at which done was first seen.
    task automatic send_word(input int u, input logic [63:0] data, input int n,
                             input int gap_at, input int gap_len, output int done_at);
        int t;
        int e;
        t = 0;
        while (!ready_s[u] && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("idle_wait", 64'(ready_s[u]), 64'd1);
        done_at = -1;
        e = 0;
        start_s[u] = 1'b1;
        @(posedge clk); #1;
        start_s[u] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    vld_s[u] = 1'b0;
                    @(posedge clk); #1;
                    e++;
                    if (done_s[u] && done_at < 0) done_at = e;
                end
            end
            vld_s[u] = 1'b1;
            din_s[u] = data[k];
            @(posedge clk); #1;
            e++;
            if (done_s[u] && done_at < 0) done_at = e;
        end
        vld_s[u] = 1'b0;
        din_s[u] = 1'b0;
    endtask

    initial begin
        int d;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0;
            din_s[u]   = 1'b0;
            vld_s[u]   = 1'b0;
            ordy_s[u]  = 1'b1;
        end
        rst_n = 1'b1;

        check("pin_enc4_1011",  model_encode(64'hB, 4, 0),     64'h59);
        check("pin_enc4_0110",  model_encode(64'h6, 4, 0),     64'h33);
        check("pin_enc11_001",  model_encode(64'h001, 11, 1),  64'h8013);
        check("pin_enc11_7ff",  model_encode(64'h7FF, 11, 1),  64'hFFFF);

        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(ready_s[0]), 64'd1);
        check("rst_done",  64'(done_s[0]),  64'd0);
        check("rst_dout",  64'(dout4),      64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous word 1,1,0,1
        send_word(0, 64'hB, 4, -1, 0, d);
        check("t1_latency", 64'(d), 64'd4);
        check("t1_dout", 64'(dout4), 64'h59);
        @(posedge clk); #1;
        check("t1_ready_after", 64'(ready_s[0]), 64'd1);
        check("t1_done_after",  64'(done_s[0]),  64'd0);

        // Same word with a three-cycle valid gap between bit1 and bit2
        send_word(0, 64'hB, 4, 2, 3, d);
        check("t2_latency", 64'(d), 64'd7);
        check("t2_dout", 64'(dout4), 64'h59);
        @(posedge clk); #1;

        // Backpressure with start pulsed while held in DONE
        ordy_s[0] = 1'b0;
        send_word(0, 64'h6, 4, -1, 0, d);
        check("t3_latency", 64'(d), 64'd4);
        for (int i = 0; i < 4; i++) begin
            start_s[0] = (i == 1);
            @(posedge clk); #1;
            check("t3_done_held", 64'(done_s[0]),  64'd1);
            check("t3_not_ready", 64'(ready_s[0]), 64'd0);
            check("t3_dout_held", 64'(dout4),      64'h33);
        end
        start_s[0] = 1'b0;
        ordy_s[0]  = 1'b1;
        @(posedge clk); #1;
        check("t3_release_ready", 64'(ready_s[0]), 64'd1);
        check("t3_release_done",  64'(done_s[0]),  64'd0);
        check("t3_dout_kept",     64'(dout4),      64'h33);

        // Reset after two bits of a word
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        vld_s[0] = 1'b1;
        din_s[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vld_s[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t4_rst_ready", 64'(ready_s[0]), 64'd1);
        check("t4_rst_done",  64'(done_s[0]),  64'd0);
        check("t4_rst_dout",  64'(dout4),      64'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(0, 64'h0, 4, -1, 0, d);
        check("t4_dout_0000", 64'(dout4), 64'h00);
        send_word(0, 64'hF, 4, -1, 0, d);
        check("t4_dout_1111", 64'(dout4), 64'h7F);

        // SECDED 11-bit instance
        send_word(1, 64'h7FF, 11, -1, 0, d);
        check("t5_latency", 64'(d), 64'd11);
        check("t5_dout_7ff", 64'(dout11), 64'hFFFF);
        send_word(1, 64'h001, 11, -1, 0, d);
        check("t5_dout_001", 64'(dout11), 64'h8013);

        // All 4-bit words: code word and zero receive-side syndrome
        for (int w = 0; w < 16; w++) begin
            send_word(0, 64'(w), 4, -1, 0, d);
            check("t6_dout", 64'(dout4), model_encode(64'(w), 4, 0));
            check("t6_syndrome", 64'(syndrome(64'(dout4), 4, 3)), 64'd0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
